// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if
// Bundles the configuration write port, the start/abort/busy/done
// handshake and the dds tuning outputs of the sweep sequencer.
//   cfg_we/cfg_addr/cfg_wdata : register write port (one write per cycle)
//   start/abort               : sweep control requests
//   freq/ifreq                : tuning words to the dds core
//   busy/done/step_strobe     : sweep status
// The master modport is the controlling side (software / bench) and the
// slave modport is the sequencer itself.
interface dds_sweep_ctrl_if #(
    parameter int FW = 32
);
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          start;
    logic          abort;
    logic [FW-1:0] freq;
    logic [FW-1:0] ifreq;
    logic          busy;
    logic          done;
    logic          step_strobe;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, abort,
        input  freq, ifreq, busy, done, step_strobe
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, abort,
        output freq, ifreq, busy, done, step_strobe
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Frequency-sweep sequencer for the dds core. Software loads a start
// tuning word, a signed step, a step count, a dwell time and a mode bit;
// on start the block emits n_steps+1 tones, each held dwell+1 cycles,
// optionally repeating until aborted.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dds_sweep_ctrl_if slave modport (config port, handshake,
//           freq/ifreq tuning outputs, busy/done/step_strobe status)
// Config map: 0=start_freq 1=step 2=n_steps 3=dwell 4=ifreq 5=mode(bit0=repeat)
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int NW = 16,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dds_sweep_ctrl_if.slave     bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DWELL = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [NW-1:0] IDX_ONE = NW'(1);
    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    // Software-visible configuration registers
    logic [FW-1:0] start_freq_r;
    logic [FW-1:0] step_r;
    logic [NW-1:0] n_steps_r;
    logic [DW-1:0] dwell_r;
    logic [FW-1:0] ifreq_r;
    logic          repeat_r;

    // Working copies taken at start so that config writes during a sweep
    // only affect the next one
    logic [FW-1:0] w_start;
    logic [FW-1:0] w_step;
    logic [NW-1:0] w_n_steps;
    logic [DW-1:0] w_dwell;
    logic          w_repeat;

    logic [1:0]    state;
    logic [NW-1:0] idx;
    logic [DW-1:0] cnt;
    logic [FW-1:0] freq_r;
    logic          busy_r;
    logic          done_r;
    logic          strobe_r;

    // Config writes are accepted in every state; ifreq is driven straight
    // from its register so a write shows up on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_freq_r <= '0;
            step_r       <= '0;
            n_steps_r    <= '0;
            dwell_r      <= '0;
            ifreq_r      <= '0;
            repeat_r     <= 1'b0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                3'd0:    start_freq_r <= bus.cfg_wdata[FW-1:0];
                3'd1:    step_r       <= bus.cfg_wdata[FW-1:0];
                3'd2:    n_steps_r    <= bus.cfg_wdata[NW-1:0];
                3'd3:    dwell_r      <= bus.cfg_wdata[DW-1:0];
                3'd4:    ifreq_r      <= bus.cfg_wdata[FW-1:0];
                3'd5:    repeat_r     <= bus.cfg_wdata[0];
                default: ;
            endcase
        end
    end

    // Sweep sequencer. done and step_strobe are single-cycle pulses, so
    // they default low every edge. abort overrides everything, including a
    // simultaneous start, and leaves freq at its current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            freq_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            strobe_r  <= 1'b0;
            w_start   <= '0;
            w_step    <= '0;
            w_n_steps <= '0;
            w_dwell   <= '0;
            w_repeat  <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            strobe_r <= 1'b0;
            if (bus.abort) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            w_start   <= start_freq_r;
                            w_step    <= step_r;
                            w_n_steps <= n_steps_r;
                            w_dwell   <= dwell_r;
                            w_repeat  <= repeat_r;
                            freq_r    <= start_freq_r;
                            busy_r    <= 1'b1;
                            idx       <= '0;
                            cnt       <= dwell_r;
                            state     <= DWELL;
                        end
                    end
                    DWELL: begin
                        // cnt counts down the remaining hold cycles of the
                        // current tone; at zero the next tone is loaded.
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end else if (idx < w_n_steps) begin
                            freq_r   <= freq_r + w_step;
                            idx      <= idx + IDX_ONE;
                            cnt      <= w_dwell;
                            strobe_r <= 1'b1;
                        end else if (w_repeat) begin
                            freq_r   <= w_start;
                            idx      <= '0;
                            cnt      <= w_dwell;
                            strobe_r <= 1'b1;
                        end else begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.freq        = freq_r;
    assign bus.ifreq       = ifreq_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.step_strobe = strobe_r;

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the tuning inputs (freq, ifreq) of the dds core. Software loads a start tuning word, a signed step, a step count and a dwell time through a small register-write port. The block then steps the dds through a linear chirp or hop sequence under a start/abort/busy/done handshake. It sits between the control interface and the dds instance, and is the only driver of the dds tuning inputs.

Parameters:
FW, 32, tuning-word width of freq, ifreq, start and step registers
NW, 16, step-count register width
DW, 16, dwell counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe, one write per cycle
cfg_addr  in  3  0=start_freq, 1=step (signed), 2=n_steps, 3=dwell, 4=ifreq, 5=mode (bit0=repeat); 6,7 ignored
cfg_wdata  in  32  write data, low-order bits used for narrower registers
start  in  1  level-sampled start request
abort  in  1  stop sweep
freq  out  FW  tuning word to dds freq input
ifreq  out  FW  tuning word to dds ifreq input
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal sweep completion
step_strobe  out  1  one-cycle pulse coincident with every freq change after the first tone

Behaviour:
- Reset (async, rst_n=0): all config registers 0, freq=0, ifreq=0, busy=0, done=0, step_strobe=0, state IDLE. Reset mid-sweep aborts immediately, with no done pulse.
- Config registers: written on any edge with cfg_we=1, including while busy. ifreq output follows register 4 on the next cycle.
- Start snapshot: start_freq, step, n_steps, dwell and mode are copied into working registers on start acceptance. A write during a sweep takes effect at the next start.
- FSM states: IDLE, DWELL, DONE.
- IDLE: start=1 and abort=0 -> next edge: freq<=start_freq, busy<=1, idx<=0, cnt<=dwell, state DWELL. In any other state, start is ignored.
- DWELL:
  - cnt>0: cnt decrements.
  - cnt==0 and idx<n_steps: freq<=freq+step, idx++, cnt<=dwell, step_strobe=1 for that cycle.
  - cnt==0, idx==n_steps, repeat=1: freq<=start snapshot, idx<=0, cnt<=dwell, step_strobe=1.
  - cnt==0, idx==n_steps, repeat=0: go DONE.
- Tone timing: each tone is held dwell+1 cycles. A sweep emits n_steps+1 tones. n_steps=0 gives one tone then DONE.
- DONE: done=1 and busy=0 for exactly one cycle, freq holds last tone, next state IDLE. Start can be accepted in the cycle after DONE.
- abort=1 in any state: next edge state IDLE, busy=0, done=0, step_strobe=0, freq holds current value. abort beats start in the same cycle.
- Arithmetic: freq+step is modulo 2^FW (two's-complement step, wraps silently, no saturation). Counters are unsigned.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- start=16, step=16, n_steps=3, dwell=1, pulse start -> freq 16,16,32,32,48,48,64,64 over 8 cycles. step_strobe at the 32/48/64 edges. Then done=1 for one cycle, busy=0, freq stays 64.
- Wrap: start=0xFFFFFFF0, step=0x20, n_steps=1, dwell=0 -> freq 0xFFFFFFF0 then 0x00000010, then done.
- Negative step: start=128, step=0xFFFFFFF0 (-16), n_steps=2, dwell=0 -> 128,112,96, then done.
- Repeat: mode=1, start=8, step=8, n_steps=1, dwell=0 -> 8,16,8,16,… with busy held high and no done. Abort then gives busy=0 next cycle, freq frozen, done never asserted.
- Config during busy: write start_freq=999 mid-sweep -> current sweep unchanged. Next start begins at 999. A write of ifreq=128 appears on ifreq the next cycle, even while busy.
- Async reset mid-sweep: drop rst_n between edges -> all outputs 0 immediately. After release, start is required to resume.
